// File: rtl/sr_drv_pkg.sv
// Shared types and command encodings for the SR latch driver and its timer.
// Used by sr_latch_driver (optional SR_DRV_STATS_EN build) and sr_drv_timer.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } sr_drv_state_t;

    // {s,r} encodings; the SR element sets q on 01 and clears it on 10.
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_Q1   = 2'b01;
    localparam logic [1:0] CMD_Q0   = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] cmd_for(input logic tgt);
        return tgt ? CMD_Q1 : CMD_Q0;
    endfunction

    // Consistent feedback showing the target; q == q_bar never matches.
    function automatic logic fb_match(input logic q, input logic qbar, input logic tgt);
        return (q == tgt) && (qbar == ~tgt);
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter shared by the DRIVE (pulse width) and WAIT (timeout) phases.
// Load has priority over count-enable; the count stops at zero.
module sr_drv_timer
    import sr_drv_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Request-driven initiator for an SR storage element: pulses s/r only when q must change,
// then confirms via q/q_bar feedback. Define SR_DRV_STATS_EN to add ok_cnt/err_cnt outputs.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_val,
    input  logic       q_fb,
    input  logic       qbar_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
`ifdef SR_DRV_STATS_EN
    output logic       err,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
`else
    output logic       err
`endif
);

    localparam int CNT_W = $clog2(max_int(PULSE_W, TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(TIMEOUT - 1);

    sr_drv_state_t    state_reg, state_next;
    logic             tgt_reg, tgt_next;
    logic [1:0]       cmd_reg, cmd_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_zero;

    sr_drv_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            tgt_reg   <= 1'b0;
            cmd_reg   <= CMD_HOLD;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            cmd_reg   <= cmd_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tgt_next     = tgt_reg;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    tgt_next = req_val;
                    if (fb_match(q_fb, qbar_fb, req_val)) begin
                        state_next = DONE;
                    end else begin
                        state_next   = DRIVE;
                        tmr_load     = 1'b1;
                        tmr_load_val = DRIVE_LOAD;
                    end
                end
            end
            // Feedback is deliberately ignored here so the full pulse is always issued.
            DRIVE: begin
                if (tmr_zero) begin
                    state_next   = WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = WAIT_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT: begin
                if (fb_match(q_fb, qbar_fb, tgt_reg)) begin
                    state_next = DONE;
                end else if (tmr_zero) begin
                    state_next = ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_reg.
        cmd_next  = (state_next == DRIVE) ? cmd_for(tgt_next) : CMD_HOLD;
        done_next = (state_next == DONE);
        err_next  = (state_next == ERR);
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign s         = cmd_reg[1];
    assign r         = cmd_reg[0];
    assign done      = done_reg;
    assign err       = err_reg;

`ifdef SR_DRV_STATS_EN
    logic [7:0] ok_cnt_reg;
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_cnt_reg  <= 8'h00;
            err_cnt_reg <= 8'h00;
        end else begin
            if (done_next && (ok_cnt_reg != 8'hFF)) begin
                ok_cnt_reg <= ok_cnt_reg + 8'h01;
            end
            if (err_next && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'h01;
            end
        end
    end

    assign ok_cnt  = ok_cnt_reg;
    assign err_cnt = err_cnt_reg;
`endif

    a_no_cmd_11: assert property (@(posedge clk) disable iff (!reset_n) !(s && r));
    a_done_err_excl: assert property (@(posedge clk) disable iff (!reset_n) !(done && err));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver (PULSE_W=2, TIMEOUT=8) with a one-edge SR element model;
// stats outputs are checked too when SR_DRV_STATS_EN is defined.
module tb_sr_latch_driver;

    logic clk;
    logic reset_n;
    logic req_valid;
    logic req_ready;
    logic req_val;
    logic q_fb;
    logic qbar_fb;
    logic s;
    logic r;
    logic busy;
    logic done;
    logic err;
`ifdef SR_DRV_STATS_EN
    logic [7:0] ok_cnt;
    logic [7:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // SR element model: when disabled, q follows the forced value (also used to preset it).
    logic model_en;
    logic q_model;
    logic q_force;
    logic qbar_force;

    always @(posedge clk) begin
        if (!model_en)
            q_model <= q_force;
        else if ({s, r} == 2'b01)
            q_model <= 1'b1;
        else if ({s, r} == 2'b10)
            q_model <= 1'b0;
    end

    assign q_fb    = model_en ? q_model  : q_force;
    assign qbar_fb = model_en ? ~q_model : qbar_force;

    sr_latch_driver #(
        .PULSE_W (2),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .q_fb      (q_fb),
        .qbar_fb   (qbar_fb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .done      (done),
`ifdef SR_DRV_STATS_EN
        .err       (err),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt)
`else
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_model(input logic val);
        model_en   = 1'b0;
        q_force    = val;
        qbar_force = ~val;
        step();
        model_en = 1'b1;
    endtask

    task automatic force_fb(input logic qv, input logic qbv);
        model_en   = 1'b0;
        q_force    = qv;
        qbar_force = qbv;
    endtask

    // Presents one request in the current cycle; returns in cycle T+1.
    task automatic accept(input string tag, input logic val);
        req_valid = 1'b1;
        req_val   = val;
        check({tag, "_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    int s_n, r_n, done_n, err_n, both_n, err_at;
    bit seen;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_val   = 1'b0;
        force_fb(1'b0, 1'b1);
        step();
        step();

        // 1. Reset state, then async reset in the middle of DRIVE.
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        step();
        check("rel_ready", req_ready, 1);
        check("rel_busy", busy, 0);
        accept("rst_acc", 1'b1);
        check("rst_drive_r", r, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_s", s, 0);
        check("async_r", r, 0);
        check("async_busy", busy, 0);
        #1 reset_n = 1'b1;
        step();
        check("post_ready", req_ready, 1);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_err", err, 0);
        $display("[TB] txn reset-mid-drive");

        // 2. Set from q=0: r pulse at T+1,T+2, hold at T+3, done at T+4, ready at T+5.
        init_model(1'b0);
        accept("set", 1'b1);
        check("set_t1_sr", {s, r}, 2'b01);
        check("set_t1_busy", busy, 1);
        check("set_t1_ready", req_ready, 0);
        step();
        check("set_t2_sr", {s, r}, 2'b01);
        step();
        check("set_t3_sr", {s, r}, 2'b00);
        check("set_t3_done", done, 0);
        step();
        check("set_t4_done", done, 1);
        check("set_t4_err", err, 0);
        step();
        check("set_t5_done", done, 0);
        check("set_t5_ready", req_ready, 1);
        $display("[TB] txn set q=1");

        // 3. Clear from q=1, then a skip request that needs no pulse.
        accept("clr", 1'b0);
        s_n = 0; r_n = 0; done_n = 0; err_n = 0;
        for (int i = 1; i <= 8; i++) begin
            s_n += int'(s); r_n += int'(r); done_n += int'(done); err_n += int'(err);
            if (i == 4) check("clr_t4_done", done, 1);
            step();
        end
        check("clr_s_cycles", s_n, 2);
        check("clr_r_cycles", r_n, 0);
        check("clr_done_cycles", done_n, 1);
        check("clr_err_cycles", err_n, 0);
        $display("[TB] txn clear q=0");
        accept("skip", 1'b0);
        check("skip_t1_done", done, 1);
        check("skip_t1_sr", {s, r}, 2'b00);
        step();
        check("skip_t2_done", done, 0);
        check("skip_t2_ready", req_ready, 1);
        $display("[TB] txn skip q=0");

        // 4/5. Timeout with stuck feedback, then with inconsistent q==q_bar.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) force_fb(1'b0, 1'b1);
            else        force_fb(1'b1, 1'b1);
            accept(k == 0 ? "tmo" : "inc", 1'b1);
            s_n = 0; r_n = 0; done_n = 0; err_n = 0; both_n = 0; err_at = 0;
            for (int i = 1; i <= 12; i++) begin
                if (err && err_at == 0) err_at = i;
                s_n += int'(s); r_n += int'(r); done_n += int'(done); err_n += int'(err);
                both_n += int'(done && err);
                step();
            end
            check(k == 0 ? "tmo_err_at" : "inc_err_at", err_at, 11);
            check(k == 0 ? "tmo_err_cycles" : "inc_err_cycles", err_n, 1);
            check(k == 0 ? "tmo_done_cycles" : "inc_done_cycles", done_n, 0);
            check(k == 0 ? "tmo_r_cycles" : "inc_r_cycles", r_n, 2);
            check(k == 0 ? "tmo_s_cycles" : "inc_s_cycles", s_n, 0);
            check(k == 0 ? "tmo_ready" : "inc_ready", req_ready, 1);
            $display("[TB] txn %s", k == 0 ? "timeout" : "inconsistent-fb");
        end

        // 6. Busy lock-out: request held with toggling value; re-accept right after DONE.
        init_model(1'b0);
        req_valid = 1'b1;
        req_val   = 1'b1;
        check("lock_acc_ready", req_ready, 1);
        step();
        s_n = 0; r_n = 0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("lock_t%0d_ready", i), req_ready, 0);
            s_n += int'(s); r_n += int'(r);
            if (i == 4) check("lock_t4_done", done, 1);
            req_val = ~req_val;
            step();
        end
        check("lock_r_cycles", r_n, 2);
        check("lock_s_cycles", s_n, 0);
        req_val = 1'b0;
        check("lock_t5_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("reacc_t6_sr", {s, r}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check("reacc_done_seen", seen, 1);
        step();
        $display("[TB] txn lock-out and re-accept");

`ifdef SR_DRV_STATS_EN
        check("stats_ok", ok_cnt, 8'd5);
        check("stats_err", err_cnt, 8'd2);
        force_fb(1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            accept("sat", 1'b1);
            repeat (11) step();
        end
        check("stats_err_sat", err_cnt, 8'hFF);
        check("stats_ok_hold", ok_cnt, 8'd5);
        $display("[TB] txn 300 forced timeouts");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
